// File: rtl/data_bus_if.sv
// Data-side bus interface: turns the memory stage's combinational request into a
// single-beat Wishbone B3 classic cycle and stalls the pipeline until it completes.
module data_bus_if #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_data,
    output logic [31:0] mem_rdata,
    output logic        stall_req,
    input  logic        stall_i,
    input  logic        flush,
    output logic        bus_err,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a request is taken when mem_ce=1 and flush=0 in IDLE; the memory
    // stage holds it (stall_req=1) until the cycle in which wb_ack_i=1 returns data.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_BUSY       = 2'd1,
        ST_WAIT_STALL = 2'd2
    } state_t;

    localparam int unsigned       TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TO_LAST_I);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_cyc;
    logic               r_stb;
    logic               r_we;
    logic [31:0]        r_adr;
    logic [3:0]         r_sel;
    logic [31:0]        r_dat;
    logic [31:0]        r_rdata;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_bus_err;

    logic               w_issue;
    logic               w_ack_take;
    logic               w_abort;
    logic               w_drop;
    logic               w_timeout_hit;

    always_comb begin
        w_next_state  = r_state;
        w_issue       = 1'b0;
        w_ack_take    = 1'b0;
        w_abort       = 1'b0;
        w_drop        = 1'b0;
        stall_req     = 1'b0;
        mem_rdata     = 32'h0;
        w_timeout_hit = (TIMEOUT != 0) && (r_cnt == TO_LAST);

        case (r_state)
            ST_IDLE: begin
                stall_req = mem_ce & ~flush;
                if (mem_ce && !flush) begin
                    w_issue      = 1'b1;
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // flush outranks both ack and timeout
                if (flush) begin
                    w_drop       = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (wb_ack_i) begin
                    mem_rdata    = wb_dat_i;
                    w_ack_take   = 1'b1;
                    w_drop       = 1'b1;
                    w_next_state = stall_i ? ST_WAIT_STALL : ST_IDLE;
                end else begin
                    stall_req = 1'b1;
                    if (w_timeout_hit) begin
                        w_abort      = 1'b1;
                        w_drop       = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_WAIT_STALL: begin
                if (flush) begin
                    w_next_state = ST_IDLE;
                end else begin
                    mem_rdata = r_rdata;
                    if (!stall_i) begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= 32'h0;
            r_sel     <= 4'h0;
            r_dat     <= 32'h0;
            r_rdata   <= 32'h0;
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_abort;
            if (w_issue) begin
                r_cyc <= 1'b1;
                r_stb <= 1'b1;
                r_we  <= mem_we;
                r_adr <= mem_addr;
                r_sel <= mem_sel;
                r_dat <= mem_data;
                r_cnt <= '0;
            end else if (w_drop) begin
                r_cyc <= 1'b0;
                r_stb <= 1'b0;
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_ack_take) begin
                r_rdata <= wb_dat_i;
            end
        end
    end

    assign wb_cyc_o    = r_cyc;
    assign wb_stb_o    = r_stb;
    assign wb_we_o     = r_we;
    assign wb_adr_o    = r_adr;
    assign wb_sel_o    = r_sel;
    assign wb_dat_o    = r_dat;
    assign bus_err     = r_bus_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_data_bus_if.sv
// Bench for data_bus_if: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a transaction-level model.
module tb_data_bus_if;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ce, mem_we, stall_i, flush, wb_ack_i;
    logic [31:0] mem_addr, mem_data, wb_dat_i;
    logic [3:0]  mem_sel;
    logic [31:0] mem_rdata, wb_adr_o, wb_dat_o;
    logic        stall_req, bus_err, wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 1'b0;

    data_bus_if #(.TIMEOUT(TO), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
        .mem_data(mem_data), .mem_rdata(mem_rdata), .stall_req(stall_req),
        .stall_i(stall_i), .flush(flush), .bus_err(bus_err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .o_dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'h0, act}, {31'h0, exp});
    endtask

    // model: queue of accepted requests still on the bus {we, sel, adr, dat}
    logic [68:0] exp_q[$];
    int          m_waits   = 0;
    bit          m_frozen  = 1'b0;
    bit          m_err     = 1'b0;
    logic [31:0] m_latched = 32'h0;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_waits   = 0;
            m_frozen  = 1'b0;
            m_err     = 1'b0;
            m_latched = 32'h0;
        end else begin
            m_err = 1'b0;
            if (exp_q.size() != 0) begin
                if (flush) begin
                    exp_q.delete();
                end else if (wb_ack_i) begin
                    exp_q.delete();
                    m_latched = wb_dat_i;
                    m_frozen  = stall_i;
                end else if (m_waits + 1 == TO) begin
                    exp_q.delete();
                    m_err = 1'b1;
                end else begin
                    m_waits++;
                end
            end else if (m_frozen) begin
                if (flush || !stall_i) m_frozen = 1'b0;
            end else if (mem_ce && !flush) begin
                exp_q.push_back({mem_we, mem_sel, mem_addr, mem_data});
                m_waits = 0;
            end
        end
    end

    // compare process: outputs are sampled mid-cycle
    always @(negedge clk) begin
        logic        e_stall;
        logic [31:0] e_rdata;
        logic [68:0] e;
        if (checking && !rst) begin
            if (exp_q.size() != 0) begin
                e_stall = !flush && !wb_ack_i;
                e_rdata = (!flush && wb_ack_i) ? wb_dat_i : 32'h0;
                e = exp_q[0];
                check1("m_we",  wb_we_o,  e[68]);
                check("m_sel",  {28'h0, wb_sel_o}, {28'h0, e[67:64]});
                check("m_adr",  wb_adr_o, e[63:32]);
                check("m_dat",  wb_dat_o, e[31:0]);
            end else if (m_frozen) begin
                e_stall = 1'b0;
                e_rdata = flush ? 32'h0 : m_latched;
            end else begin
                e_stall = mem_ce && !flush;
                e_rdata = 32'h0;
            end
            check1("m_cyc",   wb_cyc_o,  exp_q.size() != 0);
            check1("m_stb",   wb_stb_o,  exp_q.size() != 0);
            check1("m_stall", stall_req, e_stall);
            check("m_rdata",  mem_rdata, e_rdata);
            check1("m_err",   bus_err,   m_err);
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic ce, input logic we, input logic [31:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat);
        mem_ce = ce; mem_we = we; mem_addr = adr; mem_sel = sel; mem_data = dat;
    endtask

    task automatic slave(input logic ack, input logic [31:0] di);
        wb_ack_i = ack; wb_dat_i = di;
    endtask

    task automatic lit(input string name, input logic cyc, input logic stall,
                       input logic [31:0] rdata);
        @(negedge clk);
        check1({name, "_cyc"}, wb_cyc_o, cyc);
        check1({name, "_stall"}, stall_req, stall);
        check({name, "_rdata"}, mem_rdata, rdata);
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        rst = 1'b1; stall_i = 1'b0; flush = 1'b0;
        req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        slave(1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checking = 1'b1;
        @(negedge clk);
        check1("rst_cyc", wb_cyc_o, 1'b0);
        check1("rst_err", bus_err, 1'b0);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_state", {30'h0, dbg_state}, 32'h0);

        // load, two wait states
        tick(); req(1'b1, 1'b0, 32'h40, 4'hF, 32'h0); slave(1'b0, 32'h0);
        lit("ld_issue", 1'b0, 1'b1, 32'h0);
        tick(); lit("ld_w1", 1'b1, 1'b1, 32'h0);
        tick(); lit("ld_w2", 1'b1, 1'b1, 32'h0);
        tick(); slave(1'b1, 32'hDEADBEEF);
        lit("ld_ack", 1'b1, 1'b0, 32'hDEADBEEF);
        tick(); req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); slave(1'b0, 32'h0);
        lit("ld_end", 1'b0, 1'b0, 32'h0);

        // store, immediate ack
        tick(); req(1'b1, 1'b1, 32'h100, 4'b0011, 32'h12341234);
        lit("st_issue", 1'b0, 1'b1, 32'h0);
        tick(); slave(1'b1, 32'h0);
        lit("st_ack", 1'b1, 1'b0, 32'h0);
        check1("st_we", wb_we_o, 1'b1);
        check("st_adr", wb_adr_o, 32'h100);
        check("st_sel", {28'h0, wb_sel_o}, 32'h3);
        check("st_dat", wb_dat_o, 32'h12341234);
        tick(); req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); slave(1'b0, 32'h0);
        lit("st_end", 1'b0, 1'b0, 32'h0);

        // ack while the pipeline is frozen elsewhere
        tick(); req(1'b1, 1'b0, 32'h80, 4'hF, 32'h0);
        tick(); slave(1'b1, 32'hCAFEF00D); stall_i = 1'b1;
        lit("ws_ack", 1'b1, 1'b0, 32'hCAFEF00D);
        tick(); slave(1'b0, 32'h0);
        lit("ws_hold1", 1'b0, 1'b0, 32'hCAFEF00D);
        check("ws_state", {30'h0, dbg_state}, 32'h2);
        tick(); lit("ws_hold2", 1'b0, 1'b0, 32'hCAFEF00D);
        tick(); stall_i = 1'b0;
        lit("ws_release", 1'b0, 1'b0, 32'hCAFEF00D);
        tick(); req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        lit("ws_idle", 1'b0, 1'b0, 32'h0);
        check("ws_state_idle", {30'h0, dbg_state}, 32'h0);

        // flush in the second busy cycle, then a late ack
        tick(); req(1'b1, 1'b0, 32'hC0, 4'hF, 32'h0);
        tick(); lit("fl_w1", 1'b1, 1'b1, 32'h0);
        tick(); flush = 1'b1;
        lit("fl_flush", 1'b1, 1'b0, 32'h0);
        tick(); flush = 1'b0; req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); slave(1'b1, 32'hBAD0BAD0);
        lit("fl_late_ack", 1'b0, 1'b0, 32'h0);
        tick(); slave(1'b0, 32'h0);
        lit("fl_end", 1'b0, 1'b0, 32'h0);

        // timeout after four ack-less busy cycles
        tick(); req(1'b1, 1'b0, 32'hE0, 4'hF, 32'h0);
        for (int i = 0; i < TO; i++) begin
            tick(); lit("to_busy", 1'b1, 1'b1, 32'h0);
            check1("to_noerr", bus_err, 1'b0);
        end
        tick(); req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        lit("to_abort", 1'b0, 1'b0, 32'h0);
        check1("to_err", bus_err, 1'b1);
        tick(); check1("to_err_once", bus_err, 1'b0);

        // reset in the middle of a cycle, then a fresh request
        tick(); req(1'b1, 1'b0, 32'h200, 4'hF, 32'h0);
        tick(); tick(); rst = 1'b1; req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick(); rst = 1'b0;
        lit("rs_after", 1'b0, 1'b0, 32'h0);
        check("rs_adr", wb_adr_o, 32'h0);
        check1("rs_err", bus_err, 1'b0);
        tick(); req(1'b1, 1'b0, 32'h204, 4'hF, 32'h0);
        lit("rs_issue", 1'b0, 1'b1, 32'h0);
        tick(); slave(1'b1, 32'h5A5A1234);
        lit("rs_ack", 1'b1, 1'b0, 32'h5A5A1234);
        tick(); req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); slave(1'b0, 32'h0);
        lit("rs_end", 1'b0, 1'b0, 32'h0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst     = ($urandom_range(0, 199) == 0);
            flush   = ($urandom_range(0, 99) < 4);
            stall_i = ($urandom_range(0, 99) < 20);
            req($urandom_range(0, 99) < 60, 1'(($urandom_range(0, 1))), $urandom,
                4'($urandom_range(0, 15)), $urandom);
            slave($urandom_range(0, 99) < 35, $urandom);
        end
        tick();
        rst = 1'b0; flush = 1'b0; stall_i = 1'b0;
        req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); slave(1'b0, 32'h0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
